// File: rtl/ro_puf_eval.sv
// rtl/ro_puf_eval.sv - ring-oscillator PUF evaluator: pairwise edge-count race per response bit
module ro_puf_eval #(
    parameter int NUM_RO = 16,
    parameter int RESP_W = 8,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1000,
    localparam int SEL_W = $clog2(NUM_RO)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_RO-1:0]         ro_in,
    input  logic [RESP_W*2*SEL_W-1:0] challenge,
    input  logic                      start,
    output logic [NUM_RO-1:0]         ro_en,
    output logic                      busy,
    output logic                      done,
    output logic [RESP_W-1:0]         response,
    output logic                      tie
);
    localparam int IW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int TW = $clog2(WINDOW + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_COUNT,
        S_CMP,
        S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [RESP_W*2*SEL_W-1:0] chal_q;
    logic [IW-1:0]             bit_idx;
    logic [TW-1:0]             timer;
    logic [SEL_W-1:0]          sel_a, sel_b;
    logic [2:0]                sync_a, sync_b;
    logic                      edge_a, edge_b;
    logic [CNT_W-1:0]          cnt_a, cnt_b;
    logic [RESP_W-1:0]         shadow;
    logic                      shadow_tie;

    // Current pair indices come from the latched challenge, never the live input
    always_comb begin
        sel_a = chal_q[int'(bit_idx)*2*SEL_W +: SEL_W];
        sel_b = chal_q[int'(bit_idx)*2*SEL_W + SEL_W +: SEL_W];
    end

    assign edge_a = sync_a[1] & ~sync_a[2];
    assign edge_b = sync_b[1] & ~sync_b[2];
    assign busy   = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and ring enables; both rings stay powered through settle and count
    always_comb begin
        state_nxt = state;
        ro_en     = '0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ARM;
            S_ARM: begin
                ro_en     = (NUM_RO'(1) << sel_a) | (NUM_RO'(1) << sel_b);
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                ro_en = (NUM_RO'(1) << sel_a) | (NUM_RO'(1) << sel_b);
                if (timer == TW'(2)) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                ro_en = (NUM_RO'(1) << sel_a) | (NUM_RO'(1) << sel_b);
                if (timer == TW'(WINDOW - 1)) state_nxt = S_CMP;
            end
            S_CMP:    state_nxt = (bit_idx == IW'(RESP_W - 1)) ? S_DONE : S_ARM;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Phase timer restarts on every state change; only settle and count are multi-cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        timer <= '0;
        else if (state_nxt != state)                       timer <= '0;
        else if (state == S_SETTLE || state == S_COUNT)    timer <= timer + TW'(1);
        else                                               timer <= '0;
    end

    // Two synchronizer flops per selected ring plus a third for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], ro_in[sel_a]};
            sync_b <= {sync_b[1:0], ro_in[sel_b]};
        end
    end

    // Saturating edge counters, cleared at the start of every pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (state == S_ARM) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (state == S_COUNT) begin
            if (edge_a && cnt_a != {CNT_W{1'b1}}) cnt_a <= cnt_a + CNT_W'(1);
            if (edge_b && cnt_b != {CNT_W{1'b1}}) cnt_b <= cnt_b + CNT_W'(1);
        end
    end

    // Challenge latch, bit sequencing and shadow result; outputs only change at DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_q     <= '0;
            bit_idx    <= '0;
            shadow     <= '0;
            shadow_tie <= 1'b0;
            response   <= '0;
            tie        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    chal_q     <= challenge;
                    bit_idx    <= '0;
                    shadow     <= '0;
                    shadow_tie <= 1'b0;
                end
                S_CMP: begin
                    shadow[bit_idx] <= (cnt_a > cnt_b);
                    if (cnt_a == cnt_b) shadow_tie <= 1'b1;
                    if (bit_idx != IW'(RESP_W - 1)) bit_idx <= bit_idx + IW'(1);
                end
                S_DONE: begin
                    response <= shadow;
                    tie      <= shadow_tie;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_puf_eval.sv
// tb/tb_ro_puf_eval.sv - scoreboard bench for ro_puf_eval
module tb_ro_puf_eval;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ro_in;
    logic [23:0] challenge;
    logic        start, start_s;
    logic [3:0]  ph = '0;

    logic [7:0]  ro_en, ro_en_s;
    logic        busy, busy_s, done, done_s, tie, tie_s;
    logic [3:0]  response, response_s;

    int          cur;
    logic [7:0]  c_ro_en;
    logic        c_busy, c_done, c_tie;
    logic [3:0]  c_resp;

    typedef struct {
        logic [3:0] resp;
        logic       tie;
        int         cycles;
    } exp_t;
    exp_t sb[$];

    logic [3:0] last_resp [2];
    logic       last_tie  [2];
    int n_checks = 0;
    int n_pass   = 0;

    ro_puf_eval #(.NUM_RO(8), .RESP_W(4), .CNT_W(16), .WINDOW(64)) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .challenge(challenge), .start(start),
        .ro_en(ro_en), .busy(busy), .done(done), .response(response), .tie(tie)
    );

    ro_puf_eval #(.NUM_RO(8), .RESP_W(4), .CNT_W(4), .WINDOW(100)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .challenge(challenge), .start(start_s),
        .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(response_s), .tie(tie_s)
    );

    always #5 clk = ~clk;

    // Rings: bit 5 at clk/8, all others at clk/4, changing away from the sampling edge
    always @(negedge clk) ph <= ph + 4'd1;
    assign ro_in = {ph[1], ph[1], ph[2], ph[1], ph[1], ph[1], ph[1], ph[1]};

    assign c_ro_en = (cur == 1) ? ro_en_s    : ro_en;
    assign c_busy  = (cur == 1) ? busy_s     : busy;
    assign c_done  = (cur == 1) ? done_s     : done;
    assign c_tie   = (cur == 1) ? tie_s      : tie;
    assign c_resp  = (cur == 1) ? response_s : response;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [5:0] pr(input int a, input int b);
        return {3'(b), 3'(a)};
    endfunction

    function automatic logic [23:0] mk(input int a0, input int b0, input int a1, input int b1,
                                       input int a2, input int b2, input int a3, input int b3);
        return {pr(a3, b3), pr(a2, b2), pr(a1, b1), pr(a0, b0)};
    endfunction

    task automatic run_eval(input int which, input logic [23:0] chal, input logic [3:0] exp_resp,
                            input logic exp_tie, input int abort_at, input bit pulses);
        exp_t       e;
        int         n;
        bit         got;
        int         per_bit;
        logic [7:0] en_exp [4];
        logic [2:0] ia, ib;
        cur     = which;
        per_bit = (which == 0) ? 69 : 105;
        for (int b = 0; b < 4; b++) begin
            ia = chal[b*6 +: 3];
            ib = chal[b*6+3 +: 3];
            en_exp[b] = (8'd1 << ia) | (8'd1 << ib);
        end
        e.resp   = exp_resp;
        e.tie    = exp_tie;
        e.cycles = 4 * per_bit + 1;
        sb.push_back(e);

        @(negedge clk);
        challenge = chal;
        if (which == 0) start = 1'b1;
        else            start_s = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_s = 1'b0;
        check("busy_rise", 32'(c_busy), 32'd1);

        n   = 0;
        got = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_ro_en", 32'(c_ro_en), 32'd0);
                check("abort_busy",  32'(c_busy),  32'd0);
                check("abort_done",  32'(c_done),  32'd0);
                check("abort_resp",  32'(c_resp),  32'd0);
                check("abort_tie",   32'(c_tie),   32'd0);
                void'(sb.pop_back());
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(c_done), 32'd0);
                end
                rst_n = 1'b1;
                last_resp[0] = '0; last_resp[1] = '0;
                last_tie[0]  = 1'b0; last_tie[1] = 1'b0;
                return;
            end
            if (c_done) begin
                got = 1;
                break;
            end
            if (which == 0 && n < 4 * per_bit) begin
                if (n % per_bit == 30) check("ro_en_count", 32'(c_ro_en), 32'(en_exp[n / per_bit]));
                if (n % per_bit == 68) check("ro_en_cmp",   32'(c_ro_en), 32'd0);
            end
            if (n == 150) begin
                check("resp_hold", 32'(c_resp), 32'(last_resp[which]));
                check("tie_hold",  32'(c_tie),  32'(last_tie[which]));
            end
            if (which == 0) start = pulses && (n == 10 || n == 200);
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        e = sb.pop_front();
        if (got) begin
            check("response", 32'(c_resp), 32'(e.resp));
            check("tie",      32'(c_tie),  32'(e.tie));
            check("latency",  32'(n),      32'(e.cycles));
            check("busy_fall", 32'(c_busy), 32'd0);
            last_resp[which] = e.resp;
            last_tie[which]  = e.tie;
            @(negedge clk);
            check("done_single", 32'(c_done), 32'd0);
            if (pulses) begin
                repeat (5) @(negedge clk);
                check("no_restart", 32'(c_busy), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start_s   = 1'b0;
        challenge = '0;
        cur       = 0;
        last_resp[0] = '0; last_resp[1] = '0;
        last_tie[0]  = 1'b0; last_tie[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ro_en",  32'(ro_en),      32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_resp",   32'(response),   32'd0);
        check("rst_tie",    32'(tie),        32'd0);
        check("rst_ro_en2", 32'(ro_en_s),    32'd0);
        check("rst_busy2",  32'(busy_s),     32'd0);
        check("rst_resp2",  32'(response_s), 32'd0);
        check("rst_tie2",   32'(tie_s),      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_eval(0, mk(3, 5, 3, 5, 3, 5, 3, 5), 4'b1111, 1'b0, -1, 1'b0);
        run_eval(0, mk(5, 3, 3, 5, 5, 3, 3, 5), 4'b1010, 1'b0, -1, 1'b0);
        run_eval(0, mk(2, 2, 2, 2, 2, 2, 2, 2), 4'b0000, 1'b1, -1, 1'b0);
        run_eval(0, mk(3, 5, 3, 5, 3, 5, 3, 5), 4'b1111, 1'b0, -1, 1'b1);
        run_eval(0, mk(5, 3, 3, 5, 5, 3, 3, 5), 4'b1010, 1'b0, 2 * 69 + 30, 1'b0);
        run_eval(0, mk(3, 5, 3, 5, 3, 5, 3, 5), 4'b1111, 1'b0, -1, 1'b0);
        run_eval(1, mk(3, 1, 3, 1, 3, 1, 3, 1), 4'b0000, 1'b1, -1, 1'b0);
        run_eval(1, mk(3, 5, 3, 5, 3, 5, 3, 5), 4'b1111, 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
